// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle fetch/execute sequencer in front of the combinational
// instruction decoder. It owns the program counter and latches one 10-bit
// iiiidddddd word per step from the asynchronous-read ROM. It also handles
// the control-flow and handshake opcodes:
// JMP, OUT, LOAD, STORE, RST and HALT.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   run            start request, only looked at while idle
//   imem_addr      ROM address (always equal to pc)
//   imem_rdata     ROM word, combinational from imem_addr
//   instr          latched instruction, stable from EXEC through the wait states
//   exec_en        one-cycle commit strobe, gates register-file writes
//   mem_req/mem_we data-memory request (we=1 for STORE), held until mem_ready
//   mem_ready      data-memory accept/complete
//   out_valid      output-port data valid while an OUT waits
//   out_ready      output-port accept
//   regfile_clear  one-cycle pulse clearing the register file (RST opcode)
//   pc             current program counter
//   halted         sticky, set by HALT or by a memory timeout abort
//   mem_error      sticky, set by a memory timeout abort
//   retired        retired-instruction count, saturating
module instr_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [9:0]          imem_rdata,
  output logic [9:0]          instr,
  output logic                exec_en,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                regfile_clear,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                mem_error,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_OUT   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_RST   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // The counter holds the number of MEM_WAIT cycles already spent without
  // mem_ready. The cycle in which it would reach MEM_TIMEOUT is the last one
  // allowed, so mem_req stays up for at most MEM_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [9:0]          instr_next;
  logic [7:0]          tmo_cnt, tmo_cnt_next;
  logic                halted_next, mem_error_next;
  logic [3:0]          opcode;

  assign opcode    = instr[9:6];
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr     <= '0;
      tmo_cnt   <= '0;
      halted    <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      instr     <= instr_next;
      tmo_cnt   <= tmo_cnt_next;
      halted    <= halted_next;
      mem_error <= mem_error_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (exec_en && retired != 16'hFFFF) begin
      retired <= retired + 16'd1;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    instr_next     = instr;
    tmo_cnt_next   = tmo_cnt;
    halted_next    = halted;
    mem_error_next = mem_error;
    exec_en        = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    out_valid      = 1'b0;
    regfile_clear  = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end

      S_FETCH: begin
        instr_next = imem_rdata;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_JMP: begin
            exec_en    = 1'b1;
            pc_next    = PC_WIDTH'(instr[5:0]);
            state_next = S_FETCH;
          end
          OP_RST: begin
            exec_en       = 1'b1;
            regfile_clear = 1'b1;
            pc_next       = '0;
            state_next    = S_FETCH;
          end
          OP_HALT: begin
            exec_en     = 1'b1;
            halted_next = 1'b1;
            state_next  = S_HALT;
          end
          OP_LOAD, OP_STORE: begin
            tmo_cnt_next = '0;
            state_next   = S_MEM_WAIT;
          end
          OP_OUT: begin
            state_next = S_OUT_WAIT;
          end
          default: begin
            exec_en    = 1'b1;
            pc_next    = pc + PC_WIDTH'(1);
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        // Completion is checked before the timeout so a late ready still wins.
        if (mem_ready) begin
          exec_en    = 1'b1;
          pc_next    = pc + PC_WIDTH'(1);
          state_next = S_FETCH;
        end else if (tmo_cnt == TMO_LAST) begin
          mem_error_next = 1'b1;
          halted_next    = 1'b1;
          state_next     = S_HALT;
        end else begin
          tmo_cnt_next = tmo_cnt + 8'd1;
        end
      end

      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          exec_en    = 1'b1;
          pc_next    = pc + PC_WIDTH'(1);
          state_next = S_FETCH;
        end
      end

      S_HALT: begin
        // Terminal; only reset leaves this state.
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer (PC_WIDTH=6, MEM_TIMEOUT=4).
// Runs directed single-instruction vectors from a table, a few hand-written
// sequences, and random programs. The random programs are checked against a
// transaction-level model that predicts the commit cycle of every instruction.
module tb_instr_sequencer;
  localparam int PW = 6;
  localparam int TO = 4;
  localparam logic [9:0] W_HALT = 10'b1111_000000;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ready = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] imem_addr, pc;
  logic [9:0]    imem_rdata, instr;
  logic          exec_en, mem_req, mem_we, out_valid, regfile_clear, halted, mem_error;
  logic [15:0]   retired;
  logic [9:0]    rom [64];

  assign imem_rdata = rom[imem_addr];
  always #5 clk = ~clk;

  instr_sequencer #(.PC_WIDTH(PW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .exec_en(exec_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .out_valid(out_valid), .out_ready(out_ready), .regfile_clear(regfile_clear),
    .pc(pc), .halted(halted), .mem_error(mem_error), .retired(retired)
  );

  typedef struct { int cyc; int pc; int clr; } ev_t;
  typedef struct {
    logic [9:0] word; int dly;
    int e_exec; int e_pc; int e_req; int e_we; int e_clr; int e_halt; int e_err; int e_ret;
  } vec_t;

  ev_t got_q[$], exp_q[$];
  int  dly_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  first_exec, pc_after, req_cycles, we_seen, clr_first, viol;
  int  end_halt, end_err, end_pc, end_ret;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic bit is_hs(input logic [3:0] op);
    return (op == 4'b1011 || op == 4'b1100 || op == 4'b1010);
  endfunction

  // Transaction-level prediction: FETCH of the first instruction is cycle 1
  // (run is high in cycle 0). A single-step op commits one cycle after its
  // fetch. A handshake op with ready after d waiting cycles commits 2+d
  // cycles after its fetch. A memory op whose ready never comes within TO
  // waiting cycles aborts instead.
  task automatic model(input int limit, output int eh, output int ee, output int ep);
    int t, p, hv, di, e, d;
    bit stop;
    logic [9:0] w;
    logic [3:0] op;
    t = 1; p = 0; hv = -1; di = 0; stop = 0; ee = 0;
    exp_q.delete();
    while (!stop && t < limit) begin
      w = rom[p];
      op = w[9:6];
      d = 0;
      if (is_hs(op)) begin
        d = (di < dly_q.size()) ? dly_q[di] : 0;
        di++;
      end
      if ((op == 4'b1011 || op == 4'b1100) && d >= TO) begin
        hv = t + 2 + TO;
        ee = (hv <= limit) ? 1 : 0;
        stop = 1;
      end else begin
        e = is_hs(op) ? t + 2 + d : t + 1;
        if (e >= limit) stop = 1;
        else begin
          exp_q.push_back('{e, p, (op == 4'b0111) ? 1 : 0});
          case (op)
            4'b1001: p = int'(w[5:0]);
            4'b0111: p = 0;
            4'b1111: begin hv = e + 1; stop = 1; end
            default: p = (p + 1) % 64;
          endcase
          t = is_hs(op) ? t + 3 + d : t + 2;
        end
      end
    end
    eh = (hv >= 0 && hv <= limit) ? 1 : 0;
    ep = p;
  endtask

  // Reset, pulse run in cycle 0, run until cycle 'limit' and record commits.
  // The responders take one delay from dly_q per handshake transaction. They
  // drive random noise on the ready inputs whenever no handshake is pending.
  task automatic simulate(input int limit);
    int wcnt, cur_d;
    bit prev_req, prev_ov, prev_ex;
    wcnt = 0; cur_d = 0; prev_req = 0; prev_ov = 0; prev_ex = 0;
    got_q.delete();
    first_exec = -1; pc_after = -1; req_cycles = 0; we_seen = 0; clr_first = 0; viol = 0;
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (exec_en || mem_req || out_valid || pc != '0) viol++;
    end
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      run       = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (mem_req || out_valid) begin
        if ((mem_req && !prev_req) || (out_valid && !prev_ov)) begin
          cur_d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          wcnt = 0;
        end
        if (mem_req) mem_ready = (wcnt == cur_d);
        else out_ready = (wcnt == cur_d);
        wcnt++;
      end
      prev_req = mem_req; prev_ov = out_valid;
      #1;
      if (first_exec >= 0 && cyc == first_exec + 1) pc_after = int'(pc);
      if (cyc < limit) begin
        if (exec_en) begin
          got_q.push_back('{cyc, int'(pc), int'(regfile_clear)});
          if (first_exec < 0) begin first_exec = cyc; clr_first = int'(regfile_clear); end
        end
        if (prev_ex && exec_en) viol++;
        if (int'(mem_req) + int'(out_valid) + int'(regfile_clear) > 1) viol++;
        if (imem_addr != pc) viol++;
        if (mem_req) begin req_cycles++; if (mem_we) we_seen = 1; end
        prev_ex = exec_en;
      end else begin
        end_halt = int'(halted); end_err = int'(mem_error);
        end_pc = int'(pc); end_ret = int'(retired);
      end
    end
    if (pc_after < 0) pc_after = end_pc;
  endtask

  task automatic fill_rom(input logic [9:0] w);
    for (int k = 0; k < 64; k++) rom[k] = w;
  endtask

  vec_t vt[10];
  int   eh, ee, ep, cnt, bad;

  initial begin
    vt[0] = '{10'b0000_001010, 0, 2, 1, 0, 0, 0, 1, 0, 2};  // plain, then HALT
    vt[1] = '{10'b1001_000101, 0, 2, 5, 0, 0, 0, 1, 0, 2};  // JMP 5
    vt[2] = '{10'b0111_000011, 0, 2, 0, 0, 0, 1, 0, 0, 9};  // RST loops on itself
    vt[3] = '{10'b1111_000000, 0, 2, 0, 0, 0, 0, 1, 0, 1};  // HALT
    vt[4] = '{10'b1011_001000, 2, 5, 1, 3, 0, 0, 1, 0, 2};  // LOAD, ready 3rd cycle
    vt[5] = '{10'b1100_000001, 0, 3, 1, 1, 1, 0, 1, 0, 2};  // STORE, ready 1st cycle
    vt[6] = '{10'b1100_000001, 9, -1, 0, 4, 1, 0, 1, 1, 0}; // STORE timeout abort
    vt[7] = '{10'b1010_000000, 3, 6, 1, 0, 0, 0, 1, 0, 2};  // OUT, ready 4th cycle
    vt[8] = '{10'b1011_000000, 3, 6, 1, 4, 0, 0, 1, 0, 2};  // LOAD, ready on last cycle
    vt[9] = '{10'b1010_000111, 0, 3, 1, 0, 0, 0, 1, 0, 2};  // OUT, immediate ready

    for (int i = 0; i < 10; i++) begin
      fill_rom(W_HALT);
      rom[0] = vt[i].word;
      dly_q.delete();
      dly_q.push_back(vt[i].dly);
      simulate(20);
      chk($sformatf("v%0d_exec_cycle", i), first_exec, vt[i].e_exec);
      chk($sformatf("v%0d_pc_after", i), pc_after, vt[i].e_pc);
      chk($sformatf("v%0d_mem_req_cycles", i), req_cycles, vt[i].e_req);
      chk($sformatf("v%0d_mem_we", i), we_seen, vt[i].e_we);
      chk($sformatf("v%0d_regfile_clear", i), clr_first, vt[i].e_clr);
      chk($sformatf("v%0d_halted", i), end_halt, vt[i].e_halt);
      chk($sformatf("v%0d_mem_error", i), end_err, vt[i].e_err);
      chk($sformatf("v%0d_retired", i), end_ret, vt[i].e_ret);
      chk($sformatf("v%0d_invariants", i), viol, 0);
    end

    // Plain flow: commits in cycles 2 and 4, pc 0 -> 1 -> 2.
    fill_rom(W_HALT);
    rom[0] = 10'b0000_001010;
    rom[1] = 10'b0001_011100;
    dly_q.delete();
    simulate(5);
    chk("flow_commits", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("flow_exec0_cycle", got_q[0].cyc, 2);
      chk("flow_exec1_cycle", got_q[1].cyc, 4);
      chk("flow_exec1_pc", got_q[1].pc, 1);
    end
    chk("flow_pc", end_pc, 2);
    chk("flow_retired", end_ret, 2);

    // Wrap: JMP 63, then a plain op at the top address wraps pc to 0.
    fill_rom(W_HALT);
    rom[0]  = 10'b1001_111111;
    rom[63] = 10'b0000_000001;
    simulate(5);
    chk("wrap_commits", got_q.size(), 2);
    if (got_q.size() >= 2) chk("wrap_exec1_pc", got_q[1].pc, 63);
    chk("wrap_pc", end_pc, 0);

    // Asynchronous reset in the middle of a pending LOAD at pc=1.
    fill_rom(W_HALT);
    rom[0] = 10'b0000_000000;
    rom[1] = 10'b1011_000000;
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 20) begin @(negedge clk); cnt++; end
    chk("areset_reached_mem_wait", int'(mem_req), 1);
    chk("areset_pc_before", int'(pc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_mem_req", int'(mem_req), 0);
    chk("areset_pc", int'(pc), 0);
    chk("areset_instr", int'(instr), 0);
    chk("areset_retired", int'(retired), 0);
    chk("areset_flags", int'(halted) + int'(mem_error) + int'(exec_en) + int'(out_valid) + int'(regfile_clear), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (exec_en || mem_req || pc != '0) bad++;
    end
    chk("areset_idle_quiet", bad, 0);

    // Random programs against the transaction model.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 64; k++) rom[k] = 10'($urandom_range(0, 1023));
      dly_q.delete();
      for (int k = 0; k < 64; k++)
        dly_q.push_back(($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3)));
      model(300, eh, ee, ep);
      simulate(300);
      chk($sformatf("r%0d_commits", r), got_q.size(), exp_q.size());
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        if (got_q[k].cyc != exp_q[k].cyc || got_q[k].pc != exp_q[k].pc || got_q[k].clr != exp_q[k].clr) begin
          chk($sformatf("r%0d_commit%0d_cycle", r, k), got_q[k].cyc, exp_q[k].cyc);
          chk($sformatf("r%0d_commit%0d_pc", r, k), got_q[k].pc, exp_q[k].pc);
          chk($sformatf("r%0d_commit%0d_clear", r, k), got_q[k].clr, exp_q[k].clr);
          break;
        end
      end
      chk($sformatf("r%0d_retired", r), end_ret, exp_q.size());
      chk($sformatf("r%0d_halted", r), end_halt, eh);
      chk($sformatf("r%0d_mem_error", r), end_err, ee);
      chk($sformatf("r%0d_pc", r), end_pc, ep);
      chk($sformatf("r%0d_invariants", r), viol, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
